// File: rtl/syrk_engine.sv
// syrk_engine: streamed symmetric rank-k update C := alpha*A*A^T + beta*C over one
// triangle of an N x N signed integer matrix, loaded and drained over valid/ready ports.
module syrk_engine #(
   parameter int N  = 8,
   parameter int DW = 16,
   parameter int OW = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uplo,
   input  logic signed [DW-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic signed [OW-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done
);
   localparam int NN   = N * N;
   localparam int IW   = $clog2(N);
   localparam int AW   = $clog2(NN);
   localparam int ACCW = 2 * DW + $clog2(N) + 1;
   localparam int SW   = DW + ACCW + 1;
   localparam int FW   = (SW > OW) ? SW : OW;
   localparam logic [AW-1:0] N_A    = AW'(N);
   localparam logic [AW-1:0] LAST_A = AW'(NN - 1);
   localparam logic [IW-1:0] LAST_I = IW'(N - 1);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LD_BETA = 4'd1,
      LD_A    = 4'd2,
      LD_C    = 4'd3,
      RD      = 4'd4,
      MAC     = 4'd5,
      COMB    = 4'd6,
      OUT     = 4'd7,
      FIN     = 4'd8
   } state_t;

   function automatic logic [AW-1:0] idx(input logic [IW-1:0] r, input logic [IW-1:0] c);
      return AW'(r) * N_A + AW'(c);
   endfunction

   state_t                 state_q, state_d;
   logic signed [DW-1:0]   alpha_q, alpha_d, beta_q, beta_d, c_q, c_d;
   logic                   uplo_q, uplo_d, upd_q, upd_d;
   logic [AW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic signed [OW-1:0]   out_data_q, out_data_d;
   logic                   in_ready_q, out_valid_q, busy_q, done_q;

   logic signed [DW-1:0]   a_mem [NN];
   logic signed [DW-1:0]   c_mem [NN];

   logic                   hs_s, a_we_s, c_we_s, upd_s;
   logic signed [ACCW-1:0] prod_s;
   logic signed [FW-1:0]   res_s;

   assign hs_s   = in_valid & in_ready_q;
   assign a_we_s = hs_s & (state_q == LD_A) & ~rst;
   assign c_we_s = hs_s & (state_q == LD_C) & ~rst;
   assign upd_s  = uplo_q ? (j_q >= i_q) : (j_q <= i_q);
   // Row i and row j of A share the column index k, giving one A*A^T term per MAC cycle.
   assign prod_s = ACCW'(a_mem[idx(i_q, k_q)]) * ACCW'(a_mem[idx(j_q, k_q)]);
   assign res_s  = FW'(alpha_q) * FW'(acc_q) + FW'(beta_q) * FW'(c_q);

   assign in_ready  = in_ready_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // Operand storage, written in stream order; contents are only meaningful after a full load.
   always_ff @(posedge clk) begin
      if (a_we_s) a_mem[cnt_q] <= in_data;
      if (c_we_s) c_mem[cnt_q] <= in_data;
   end

   // Next-state logic: load sequencing, per-element read/MAC/combine, output hold.
   always_comb begin
      state_d    = state_q;
      alpha_d    = alpha_q;
      beta_d     = beta_q;
      uplo_d     = uplo_q;
      upd_d      = upd_q;
      c_d        = c_q;
      cnt_d      = cnt_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (hs_s) begin
               alpha_d = in_data;
               uplo_d  = uplo;
               state_d = LD_BETA;
            end else begin
               state_d = IDLE;
            end
         end
         LD_BETA: begin
            if (hs_s) begin
               beta_d  = in_data;
               cnt_d   = AW'(0);
               state_d = LD_A;
            end else begin
               state_d = LD_BETA;
            end
         end
         LD_A: begin
            if (hs_s && cnt_q == LAST_A) begin
               cnt_d   = AW'(0);
               state_d = LD_C;
            end else if (hs_s) begin
               cnt_d = cnt_q + AW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         LD_C: begin
            if (hs_s && cnt_q == LAST_A) begin
               cnt_d   = AW'(0);
               i_d     = IW'(0);
               j_d     = IW'(0);
               state_d = RD;
            end else if (hs_s) begin
               cnt_d = cnt_q + AW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         RD: begin
            c_d     = c_mem[idx(i_q, j_q)];
            acc_d   = ACCW'(0);
            k_d     = IW'(0);
            upd_d   = upd_s;
            state_d = upd_s ? MAC : COMB;
         end
         MAC: begin
            acc_d = acc_q + prod_s;
            if (k_q == LAST_I) begin
               state_d = COMB;
            end else begin
               k_d = k_q + IW'(1);
            end
         end
         COMB: begin
            out_data_d = upd_q ? res_s[OW-1:0] : OW'(c_q);
            state_d    = OUT;
         end
         OUT: begin
            if (out_ready && i_q == LAST_I && j_q == LAST_I) begin
               state_d = FIN;
            end else if (out_ready && j_q == LAST_I) begin
               j_d     = IW'(0);
               i_d     = i_q + IW'(1);
               state_d = RD;
            end else if (out_ready) begin
               j_d     = j_q + IW'(1);
               state_d = RD;
            end else begin
               state_d = OUT;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; status outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         alpha_q     <= DW'(0);
         beta_q      <= DW'(0);
         uplo_q      <= 1'b0;
         upd_q       <= 1'b0;
         c_q         <= DW'(0);
         cnt_q       <= AW'(0);
         i_q         <= IW'(0);
         j_q         <= IW'(0);
         k_q         <= IW'(0);
         acc_q       <= ACCW'(0);
         out_data_q  <= OW'(0);
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         alpha_q     <= alpha_d;
         beta_q      <= beta_d;
         uplo_q      <= uplo_d;
         upd_q       <= upd_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= state_d inside {IDLE, LD_BETA, LD_A, LD_C};
         out_valid_q <= (state_d == OUT);
         busy_q      <= !(state_d inside {IDLE, FIN});
         done_q      <= (state_d == FIN);
      end
   end
endmodule

// File: doc/syrk_engine.md
# syrk_engine

Parametrised symmetric rank-k update engine computing C := alpha·A·Aᵀ + beta·C on one triangle of an N×N integer matrix. It replaces the fixed-size, float-IP, free-running matrix block with a streamed, back-pressured, width- and size-generic core. Operands and results use valid/ready streams, storage is internal inferred memory, and the triangle is selected per job. It sits between the host input FIFO and the result writer.

## Interface
- N, 8: matrix dimension (2..64).
- DW, 16: signed width of alpha, beta, A and C input elements.
- OW, 48: signed output width; results are the low OW bits of the exact product sum.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- uplo  in  1  triangle select, sampled when alpha is accepted: 0 = lower (j≤i), 1 = upper (j≥i).
- in_data  in  DW  signed input word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine accepts in_data this cycle.
- out_data  out  OW  signed result element.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  a job is in progress (alpha accepted, done not yet pulsed).
- done  out  1  one-cycle pulse after the last result handshake.

## Operation
- Input order per job is alpha, beta, N·N A elements (row-major), then N·N C elements (row-major). That is 2+2N² handshakes (in_valid & in_ready).
- States:
  - IDLE: in_ready=1. Alpha handshake latches alpha and uplo, sets busy, goes to LD_BETA.
  - LD_BETA -> LD_A (N² words) -> LD_C (N² words) -> CALC. in_ready=1 in all load states.
  - CALC: visits (i,j) in row-major order.
    - Updated element (j≤i for uplo=0, j≥i for uplo=1): acc = Σk A[i][k]·A[j][k], k=0..N-1, then r = alpha·acc + beta·C[i][j], then state OUT.
    - Untouched element: r = C[i][j], sign-extended to OW, then state OUT.
  - OUT: out_valid=1 and out_data=r, held stable until out_ready. On handshake, advance to the next element in CALC. After element (N-1,N-1), go to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Arithmetic: signed two's complement. The accumulator is at least 2DW+clog2(N) bits, and the alpha·acc and beta·C terms are computed at full precision. The final sum is truncated (wrapped) to OW bits. There is no saturation.
- in_ready=0 in CALC, OUT and FIN. Words offered then are not consumed.
- Reset, including mid-job: return to IDLE. Counters and accumulator clear, stored data is discarded, and the next word accepted is treated as a new alpha.

## Timing
- Reset values: in_ready=0 in the reset cycle and 1 in the first cycle after; out_valid=0, out_data=0, busy=0, done=0.
- Load: one word per cycle at full rate, with no bubbles between phases.
- Updated element: N+2 cycles from entering CALC to out_valid. That is one memory-read cycle, N MAC cycles (one product per cycle), and one scale/combine cycle. The final MAC and the combine may be pipelined, but the N+2 cycle count is fixed.
- Untouched element: out_valid is asserted 2 cycles after entering CALC.
- Output: with out_ready held high, the next element's CALC starts in the cycle after the handshake. Back-pressure only stretches OUT and never changes any value.
- done is asserted in the cycle after the final handshake. in_ready returns to 1 in the cycle after done.
- Simultaneous events: rst dominates all handshakes in the same cycle.

## Test plan
- Lower triangle. N=2, DW=8, uplo=0, alpha=2, beta=3, A=[[1,2],[3,4]], C=all 1. Required outputs in order: 13, 1, 25, 53; then one done pulse.
- Upper triangle. Same data with uplo=1. Required outputs: 13, 25, 1, 53.
- Wrap-around. N=2, DW=8, OW=8, alpha=1, beta=0, A all 127, C all 0, uplo=0. The exact dot product is 32258 (0x7E02), so the required outputs are 2, 0, 2, 2.
- Back-pressure and input gaps. Toggle in_valid randomly and hold out_ready low for 5 cycles on each output. Results must match the no-stall run, out_data must stay stable while stalled, and no extra handshake may occur.
- Reset mid-job. Assert rst after 3 A words, then start a fresh job. in_ready must be 1 in the first cycle after reset, and the new job's results must be correct, unaffected by the stale data.
- Random regression. N=8, DW=16, OW=48, 50 random jobs with both uplo values. Compare against a reference model, check the per-element latencies above with out_ready=1, and check busy/done framing.
